// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter that merges NREQ AXI-stream requesters onto one uart tx input.
// Ownership is held from grant until the owner's tlast beat or an idle timeout.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ*DATA_W-1:0]   req_tdata,
  input  logic [NREQ-1:0]          req_tvalid,
  input  logic [NREQ-1:0]          req_tlast,
  output logic [NREQ-1:0]          req_tready,
  output logic [DATA_W-1:0]        out_tdata,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : {CW{1'b0}};
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r, ptr_s, owner_r, owner_s, pick_s, next_ptr_s, idx_s;
  logic [NREQ-1:0] grant_r, grant_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            terr_r, terr_s;
  logic            found_s, own_valid_s, own_last_s, beat_s, timeout_s;

  // Round-robin search for the first valid requester starting at ptr_r.
  always_comb begin
    pick_s  = {PW{1'b0}};
    found_s = 1'b0;
    idx_s   = {PW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      int sum;
      sum = int'(ptr_r) + k;
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end else begin
        sum = sum;
      end
      idx_s = PW'(sum);
      if (!found_s && req_tvalid[idx_s]) begin
        found_s = 1'b1;
        pick_s  = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign own_valid_s = req_tvalid[owner_r];
  assign own_last_s  = req_tlast[owner_r];
  assign next_ptr_s  = (owner_r == LAST_IDX) ? {PW{1'b0}} : owner_r + PW'(1);
  assign beat_s      = (state_r == XFER) && own_valid_s && out_tready;
  // The release fires at the end of the TIMEOUT-th consecutive idle cycle.
  assign timeout_s   = (TIMEOUT > 0) && (state_r == XFER) && !own_valid_s && (cnt_r == CNT_LAST);

  // Next-state and bookkeeping for the IDLE/XFER machine.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    grant_s = grant_r;
    terr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = XFER;
          owner_s = pick_s;
          grant_s = ONE_HOT0 << pick_s;
          cnt_s   = {CW{1'b0}};
        end else begin
          grant_s = {NREQ{1'b0}};
        end
      end
      XFER: begin
        if (beat_s && own_last_s) begin
          state_s = IDLE;
          grant_s = {NREQ{1'b0}};
          ptr_s   = next_ptr_s;
          cnt_s   = {CW{1'b0}};
        end else if (timeout_s) begin
          state_s = IDLE;
          grant_s = {NREQ{1'b0}};
          ptr_s   = next_ptr_s;
          cnt_s   = {CW{1'b0}};
          terr_s  = 1'b1;
        end else if (own_valid_s) begin
          cnt_s = {CW{1'b0}};
        end else if (cnt_r != {CW{1'b1}}) begin
          cnt_s = cnt_r + CW'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = {NREQ{1'b0}};
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      owner_r <= {PW{1'b0}};
      ptr_r   <= {PW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      grant_r <= {NREQ{1'b0}};
      terr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      grant_r <= grant_s;
      terr_r  <= terr_s;
    end
  end

  // Combinational data path from the owner; reset blocks any handshake.
  always_comb begin
    out_tdata  = req_tdata[owner_r*DATA_W +: DATA_W];
    out_tvalid = 1'b0;
    req_tready = {NREQ{1'b0}};
    if ((state_r == XFER) && !rst) begin
      out_tvalid          = own_valid_s;
      req_tready[owner_r] = out_tready;
    end else begin
      out_tvalid = 1'b0;
    end
  end

  assign grant       = grant_r;
  assign busy        = (state_r == XFER);
  assign timeout_err = terr_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus random traffic
// checked every cycle against a packet-level ownership model.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ*DW-1:0] req_tdata = '0;
  logic [NREQ-1:0] req_tvalid = '0;
  logic [NREQ-1:0] req_tlast = '0;
  logic [NREQ-1:0] req_tready;
  logic [DW-1:0]   out_tdata;
  logic            out_tvalid;
  logic            out_tready = 1'b0;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            timeout_err;

  int checks = 0;
  int failures = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_tdata(req_tdata), .req_tvalid(req_tvalid),
    .req_tlast(req_tlast), .req_tready(req_tready), .out_tdata(out_tdata),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .grant(grant),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the output (-1 = nobody), where the search starts, idle run length.
  int m_owner = -1;
  int m_ptr = 0;
  int m_idle = 0;
  bit m_terr = 1'b0;
  bit m_known = 1'b0;

  function automatic int first_from(input int p, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_owner <= -1; m_ptr <= 0; m_idle <= 0; m_terr <= 1'b0; m_known <= 1'b1;
    end else if (m_owner < 0) begin
      m_terr <= 1'b0;
      if (req_tvalid != '0) begin
        m_owner <= first_from(m_ptr, req_tvalid);
        m_idle  <= 0;
      end
    end else if (req_tvalid[m_owner] && out_tready && req_tlast[m_owner]) begin
      m_owner <= -1; m_ptr <= (m_owner + 1) % NREQ; m_idle <= 0; m_terr <= 1'b0;
    end else if (req_tvalid[m_owner]) begin
      m_idle <= 0; m_terr <= 1'b0;
    end else if (TO > 0 && m_idle + 1 == TO) begin
      m_owner <= -1; m_ptr <= (m_owner + 1) % NREQ; m_idle <= 0; m_terr <= 1'b1;
    end else begin
      m_idle <= m_idle + 1; m_terr <= 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    #2;
    if (m_known) begin
      logic [NREQ-1:0] eg, er;
      logic ev;
      eg = (m_owner < 0) ? '0 : (NREQ'(1) << m_owner);
      ev = (!rst && m_owner >= 0) ? req_tvalid[m_owner] : 1'b0;
      er = (!rst && m_owner >= 0 && out_tready) ? (NREQ'(1) << m_owner) : '0;
      chk("m_grant", 32'(grant), 32'(eg));
      chk("m_busy", 32'(busy), 32'(m_owner >= 0));
      chk("m_tvalid", 32'(out_tvalid), 32'(ev));
      chk("m_tready", 32'(req_tready), 32'(er));
      chk("m_terr", 32'(timeout_err), 32'(m_terr));
      if (ev) chk("m_tdata", 32'(out_tdata), 32'(req_tdata[m_owner*DW +: DW]));
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_tvalid = '0; req_tlast = '0; out_tready = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] g034 [6];
    logic [DW-1:0]   d035 [3];
    bit seen;
    g034 = '{4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    d035 = '{8'h41, 8'h42, 8'h43};

    // Alternating single-beat requesters 1 and 3.
    do_reset();
    req_tvalid = 4'b1010; req_tlast = 4'hF; out_tready = 1'b1; req_tdata = $urandom;
    for (int i = 0; i < 6; i++) begin
      #3 chk("rr_grant", 32'(grant), 32'(g034[i]));
      @(negedge clk);
    end

    // Three-beat packet from requester 0 while requester 2 waits.
    do_reset();
    req_tvalid = 4'b0101; req_tlast = 4'b0100; out_tready = 1'b1;
    req_tdata = '0; req_tdata[2*DW +: DW] = 8'h77; req_tdata[7:0] = d035[0];
    #3 chk("pkt_idle", 32'(grant), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_tdata[7:0] = d035[i];
      req_tlast[0] = (i == 2);
      #3 chk("pkt_data", 32'(out_tdata), 32'(d035[i]));
      chk("pkt_grant", 32'(grant), 32'h1);
    end
    @(negedge clk);
    req_tvalid = 4'b0100; req_tlast = 4'b0100;
    #3 chk("pkt_bubble", 32'(grant), 32'h0);
    @(negedge clk);
    #3 chk("pkt_next", 32'(grant), 32'h4);
    chk("pkt_next_data", 32'(out_tdata), 32'h77);

    // Long downstream stall must never time out.
    do_reset();
    req_tvalid = 4'b0001; req_tlast = 4'b0001; out_tready = 1'b0;
    seen = 1'b0;
    repeat (1001) begin
      @(negedge clk);
      #3 seen = seen | timeout_err;
    end
    chk("stall_terr", 32'(seen), 32'h0);
    chk("stall_grant", 32'(grant), 32'h1);
    out_tready = 1'b1;
    #1 chk("stall_ready", 32'(req_tready), 32'h1);
    chk("stall_valid", 32'(out_tvalid), 32'h1);
    @(negedge clk);
    req_tvalid = '0;
    #3 chk("stall_done", 32'(grant), 32'h0);

    // Owner goes quiet after one beat: release after TO idle cycles.
    do_reset();
    req_tvalid = 4'b0011; req_tlast = 4'b0000; out_tready = 1'b1;
    @(negedge clk);
    #3 chk("to_grant", 32'(grant), 32'h1);
    @(negedge clk);
    req_tvalid = 4'b0010;
    for (int c = 2; c <= 5; c++) begin
      #3 chk("to_quiet", 32'(timeout_err), 32'h0);
      chk("to_hold", 32'(grant), 32'h1);
      @(negedge clk);
    end
    #3 chk("to_pulse", 32'(timeout_err), 32'h1);
    chk("to_busy", 32'(busy), 32'h0);
    @(negedge clk);
    #3 chk("to_pulse_end", 32'(timeout_err), 32'h0);
    chk("to_next", 32'(grant), 32'h2);

    // Reset on the second beat of a packet.
    do_reset();
    req_tvalid = 4'b0001; req_tlast = 4'b0000; out_tready = 1'b1;
    @(negedge clk);
    #3 chk("mr_beat1", 32'(req_tready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mr_ready", 32'(req_tready), 32'h0);
    chk("mr_valid", 32'(out_tvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_tvalid = '0;
    #3 chk("mr_grant", 32'(grant), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_terr", 32'(timeout_err), 32'h0);

    // Pointer wraps from requester 3 to requester 0.
    do_reset();
    req_tvalid = 4'b0010; req_tlast = 4'hF; out_tready = 1'b1;
    @(negedge clk);
    #3 chk("wr_g1", 32'(grant), 32'h2);
    @(negedge clk);
    req_tvalid = 4'b1000;
    @(negedge clk);
    #3 chk("wr_g3", 32'(grant), 32'h8);
    @(negedge clk);
    req_tvalid = 4'hF;
    #3 chk("wr_bubble", 32'(grant), 32'h0);
    @(negedge clk);
    #3 chk("wr_g0", 32'(grant), 32'h1);

    // Random traffic with alternating dense and sparse valid phases.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int pct;
      pct = ((cyc / 250) % 2 == 1) ? 25 : 75;
      rst = ($urandom_range(0, 149) == 0);
      for (int b = 0; b < NREQ; b++) begin
        req_tvalid[b] = ($urandom_range(0, 99) < pct);
        req_tlast[b]  = ($urandom_range(0, 99) < 30);
      end
      req_tdata  = $urandom;
      out_tready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
